// File: rtl/fir_coef_ctrl.sv
// rtl/fir_coef_ctrl.sv - double-buffered FIR coefficient loader with commit/swap and output blanking
// Optional feature macro: FIR_COEF_FLUSH_EN (adds FLUSH state and fir_valid blanking after a swap).
module fir_coef_ctrl #(
  parameter int H = 13,
  parameter int CW = 9,
  parameter int FLUSH_CYC = 15,
  parameter logic [H*CW-1:0] INIT_COEFFS = (H*CW)'(128) << ((H-1)*CW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_start,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_data,
  input  logic          cfg_last,
  input  logic          commit,
  output logic [H*CW-1:0] coeffs,
  output logic          swap_pulse,
  output logic          fir_valid,
  output logic          busy,
  output logic          err
);

  localparam int IW = (H > 1) ? $clog2(H) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] ARMED = 3'd2;
  localparam logic [2:0] SWAP  = 3'd3;
`ifdef FIR_COEF_FLUSH_EN
  localparam logic [2:0] FLUSH = 3'd4;
  localparam int FW = $clog2(FLUSH_CYC + 1);
  logic [FW-1:0] fcnt;
`endif

  logic [2:0]    state;
  logic [IW-1:0] idx;
  logic [CW-1:0] shadow [H];
  logic          fv_q;

  assign cfg_ready = (state == LOAD);
  assign busy      = (state != IDLE);
`ifdef FIR_COEF_FLUSH_EN
  assign fir_valid = fv_q && (state != FLUSH);
`else
  assign fir_valid = fv_q;
`endif

  always_ff @(posedge clk) begin
    swap_pulse <= 1'b0;
    err        <= 1'b0;
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      coeffs <= INIT_COEFFS;
      fv_q   <= 1'b0;
      for (int i = 0; i < H; i++) shadow[i] <= '0;
`ifdef FIR_COEF_FLUSH_EN
      fcnt   <= '0;
`endif
    end else begin
      fv_q <= 1'b1;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state <= LOAD;
            idx   <= '0;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            idx <= '0;
          end else if (cfg_valid) begin
            // cfg_last must coincide exactly with the final tap; anything else is malformed
            if ((idx == IW'(H-1)) != cfg_last) begin
              err   <= 1'b1;
              state <= IDLE;
              idx   <= '0;
              for (int i = 0; i < H; i++) shadow[i] <= '0;
            end else begin
              shadow[idx] <= cfg_data;
              if (cfg_last) state <= ARMED;
              else          idx   <= idx + IW'(1);
            end
          end
        end
        ARMED: begin
          if (cfg_start) begin
            state <= LOAD;
            idx   <= '0;
          end else if (commit) begin
            state <= SWAP;
          end
        end
        SWAP: begin
          for (int i = 0; i < H; i++) coeffs[(H-1-i)*CW +: CW] <= shadow[i];
          swap_pulse <= 1'b1;
`ifdef FIR_COEF_FLUSH_EN
          state <= FLUSH;
          fcnt  <= '0;
`else
          state <= IDLE;
`endif
        end
`ifdef FIR_COEF_FLUSH_EN
        FLUSH: begin
          if (fcnt == FW'(FLUSH_CYC - 1)) state <= IDLE;
          else                            fcnt  <= fcnt + FW'(1);
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// tb/tb_fir_coef_ctrl.sv - directed plus randomized bench for fir_coef_ctrl against a tap-list model
module tb_fir_coef_ctrl;
  localparam int H = 13;
  localparam int CW = 9;
  localparam int FLUSH_CYC = 15;
`ifdef FIR_COEF_FLUSH_EN
  localparam int EXP_LOW = FLUSH_CYC;
`else
  localparam int EXP_LOW = 0;
`endif

  logic clk = 1'b0;
  logic rst, cfg_start, cfg_valid, cfg_ready, cfg_last, commit;
  logic swap_pulse, fir_valid, busy, err;
  logic [CW-1:0]   cfg_data;
  logic [H*CW-1:0] coeffs;

  int total = 0;
  int bad = 0;
  int beats[H];
  int active[H];

  always #5 clk = ~clk;

  fir_coef_ctrl #(.H(H), .CW(CW), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .commit(commit), .coeffs(coeffs), .swap_pulse(swap_pulse),
    .fir_valid(fir_valid), .busy(busy), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [H*CW-1:0] obs, input logic [H*CW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Taps listed c0 first; c0 ends up in the most significant slot.
  function automatic logic [H*CW-1:0] pack(input int v[H]);
    logic [H*CW-1:0] r = '0;
    for (int i = 0; i < H; i++) r = (r << CW) | (H*CW)'(v[i] & ((1 << CW) - 1));
    return r;
  endfunction

  task automatic model_reset;
    for (int i = 0; i < H; i++) active[i] = (i == 0) ? 128 : 0;
  endtask

  task automatic start_load;
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
  endtask

  task automatic send(input int n, input int lastpos, input bit gaps);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = CW'(beats[i]);
      cfg_last  = (i == lastpos);
      tick;
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      if (gaps) tick;
    end
  endtask

  task automatic commit_expect(input string tag, input bit should_swap);
    int sp = 0;
    int low = 0;
    commit = 1'b1;
    tick;
    commit = 1'b0;
    check({tag, "_pre_swap_coeffs"}, coeffs, pack(active));
    for (int k = 0; k < FLUSH_CYC + 6; k++) begin
      tick;
      if (swap_pulse) begin
        sp++;
        check({tag, "_coeffs_at_pulse"}, coeffs, pack(beats));
      end
      if (!fir_valid) low++;
    end
    if (should_swap) active = beats;
    check({tag, "_swap_count"}, (H*CW)'(sp), (H*CW)'(should_swap ? 1 : 0));
    check({tag, "_valid_low"}, (H*CW)'(low), (H*CW)'(should_swap ? EXP_LOW : 0));
    check({tag, "_coeffs"}, coeffs, pack(active));
    check({tag, "_busy"}, (H*CW)'(busy), '0);
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0; commit = 1'b0; cfg_data = '0;
    model_reset();
    for (int i = 0; i < H; i++) beats[i] = 0;
    repeat (3) tick;
    check("rst_fir_valid", (H*CW)'(fir_valid), '0);
    check("rst_busy", (H*CW)'(busy), '0);
    check("rst_ready", (H*CW)'(cfg_ready), '0);
    check("rst_coeffs", coeffs, pack(active));
    rst = 1'b0;
    tick;
    check("post_rst_fir_valid", (H*CW)'(fir_valid), 1);
    repeat (5) tick;
    check("idle_coeffs", coeffs, pack(active));
    check("idle_fir_valid", (H*CW)'(fir_valid), 1);
    check("idle_busy", (H*CW)'(busy), '0);

    commit_expect("idle_commit", 1'b0);

    for (int i = 0; i < H; i++) beats[i] = i + 1;
    start_load();
    check("load_ready", (H*CW)'(cfg_ready), 1);
    send(H, H - 1, 1'b0);
    check("armed_busy", (H*CW)'(busy), 1);
    check("armed_ready", (H*CW)'(cfg_ready), '0);
    check("armed_err", (H*CW)'(err), '0);
    commit_expect("seq", 1'b1);

    for (int i = 0; i < H; i++) beats[i] = int'($urandom_range(0, 511)) - 256;
    start_load();
    send(5, 4, 1'b0);
    check("short_err", (H*CW)'(err), 1);
    check("short_busy", (H*CW)'(busy), '0);
    tick;
    check("short_err_clear", (H*CW)'(err), '0);
    commit_expect("short", 1'b0);

    start_load();
    send(H, -1, 1'b0);
    check("long_err", (H*CW)'(err), 1);
    commit_expect("long", 1'b0);

    for (int i = 0; i < H; i++) beats[i] = int'($urandom_range(0, 511)) - 256;
    start_load();
    send(H, H - 1, 1'b0);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 9'd100;
    tick;
    cfg_start = 1'b0; cfg_valid = 1'b0;
    for (int i = 0; i < H; i++) beats[i] = -3;
    send(H, H - 1, 1'b0);
    commit_expect("restart", 1'b1);
    check("restart_tap0", (H*CW)'(coeffs[H*CW-1 -: CW]), (H*CW)'(9'h1FD));

    for (int i = 0; i < H; i++) beats[i] = (i % 2 == 0) ? -256 : 255;
    start_load();
    send(H, H - 1, 1'b1);
    check("gap_err", (H*CW)'(err), '0);
    commit_expect("gaps", 1'b1);

    for (int i = 0; i < H; i++) beats[i] = int'($urandom_range(0, 511)) - 256;
    start_load();
    send(H, H - 1, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_reset();
    commit_expect("rst_armed", 1'b0);

    for (int it = 0; it < 5; it++) begin
      bit gaps;
      gaps = 1'($urandom_range(0, 1));
      for (int i = 0; i < H; i++) beats[i] = int'($urandom_range(0, 511)) - 256;
      start_load();
      if ($urandom_range(0, 1) == 1) begin
        send(int'($urandom_range(1, H - 1)), -1, gaps);
        start_load();
      end
      send(H, H - 1, gaps);
      check("rand_err", (H*CW)'(err), '0);
      commit_expect("rand", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_coef_ctrl.md
FIR_COEF_CTRL -- requirements
Module: fir_coef_ctrl

Interface
REQ-001 SHALL have parameter H, default 13, number of FIR taps.
REQ-002 SHALL have parameter CW, default 9, coefficient width (signed, Q7).
REQ-003 SHALL have parameter FLUSH_CYC, default 15 (H+2), cycles FIR output is invalid after a swap.
REQ-004 SHALL have parameter INIT_COEFFS [H*CW-1:0], default {9'sd128, (H-1) x 9'sd0}, active bank value at reset.
REQ-005 SHALL have port clk, input, 1, clock; all logic on posedge clk.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port cfg_start, input, 1, pulse that opens a load sequence.
REQ-008 SHALL have port cfg_valid, input, 1, coefficient beat valid.
REQ-009 SHALL have port cfg_ready, output, 1, coefficient beat accepted when cfg_valid&cfg_ready.
REQ-010 SHALL have port cfg_data, input, CW, signed coefficient beat.
REQ-011 SHALL have port cfg_last, input, 1, marks final beat.
REQ-012 SHALL have port commit, input, 1, request to activate the loaded shadow bank.
REQ-013 SHALL have port coeffs, output, H*CW, active bank packed {c0,...,c(H-1)}, c0 in MSBs.
REQ-014 SHALL have port swap_pulse, output, 1, one-cycle pulse on the cycle coeffs changes.
REQ-015 SHALL have port fir_valid, output, 1, qualifies downstream FIR dout.
REQ-016 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-017 SHALL have port err, output, 1, one-cycle pulse on a malformed load.

Function
REQ-018 SHALL implement states IDLE, LOAD, ARMED, SWAP, FLUSH.
REQ-019 SHALL go IDLE->LOAD on cfg_start, clearing beat index idx to 0.
REQ-020 SHALL assert cfg_ready only in LOAD; cfg_ready is registered-state-derived, no combinational path from cfg_valid.
REQ-021 SHALL write each accepted beat to shadow[idx] and increment idx; first beat is c0.
REQ-022 SHALL go LOAD->ARMED when the accepted beat has idx==H-1 and cfg_last=1.
REQ-023 SHALL, on accepted beat with cfg_last=1 and idx<H-1, or idx==H-1 and cfg_last=0, pulse err, discard shadow contents, and return to IDLE.
REQ-024 SHALL, on cfg_start in LOAD or ARMED, restart LOAD with idx=0 (cfg_start has priority over a same-cycle beat, which is dropped).
REQ-025 SHALL go ARMED->SWAP on commit; commit in any other state is ignored, no err.
REQ-026 SHALL, in SWAP (one cycle), register coeffs<=shadow and assert swap_pulse in the same cycle coeffs takes the new value.
REQ-027 SHALL leave coeffs unchanged in all states except SWAP.
REQ-028 SHALL go SWAP->FLUSH, hold fir_valid=0 for exactly FLUSH_CYC cycles starting the cycle after SWAP, then go IDLE with fir_valid=1.
REQ-029 SHALL ignore cfg_start during SWAP and FLUSH (no restart, no err).
REQ-030 SHALL keep busy=1 in LOAD, ARMED, SWAP, FLUSH; 0 in IDLE.

Reset
REQ-031 SHALL on rst: state IDLE, idx 0, shadow all 0, coeffs=INIT_COEFFS, swap_pulse 0, err 0, cfg_ready 0, busy 0.
REQ-032 SHALL hold fir_valid=0 during rst and drive it 1 from the first cycle after rst deasserts.
REQ-033 SHALL abort any load, armed bank or flush when rst asserts mid-operation; no swap occurs.

Configuration
REQ-034 SHALL support macro FIR_COEF_FLUSH_EN: defined -> FLUSH state and fir_valid blanking per REQ-028; undefined -> SWAP goes directly to IDLE, FLUSH state absent, fir_valid=1 whenever not in reset.

Verification
REQ-035 Reset then idle 5 cycles -> coeffs=INIT_COEFFS (tap0=128), fir_valid=1, busy=0.
REQ-036 cfg_start, 13 beats values 1..13 with cfg_last on 13th, commit -> swap_pulse one cycle, coeffs c0=1..c12=13, fir_valid low exactly 15 cycles (flag defined).
REQ-037 cfg_start, cfg_last on 5th beat -> err one pulse, state IDLE, coeffs unchanged, subsequent commit ignored.
REQ-038 13 beats loaded, cfg_start again, 13 beats of -3, commit -> all taps 9'h1FD (-3), first load never visible.
REQ-039 Beats with cfg_valid gaps (valid every other cycle), cfg_data=-256 and 255 alternating -> coeffs exact, err=0.
REQ-040 rst asserted during ARMED, then commit -> no swap_pulse, coeffs=INIT_COEFFS.
